io_uart: RTL
============

IO_UART -- requirements
Module: io_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clk cycles per serial bit (12 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter ADDR_DATA, default 16'h1000, IO address of the data register.
REQ-003 SHALL have parameter ADDR_STAT, default 16'h2000, IO address of the status/control register.
REQ-004 SHALL have parameter RXDEPTH, default 4, RX FIFO depth in bytes; power of two, 2..16.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port resetq, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port io_rd, input, 1, CPU IO read strobe, one cycle.
REQ-008 SHALL have port io_wr, input, 1, CPU IO write strobe, one cycle.
REQ-009 SHALL have port io_addr, input, 16, CPU IO address.
REQ-010 SHALL have port io_dout, input, 16, CPU write data.
REQ-011 SHALL have port io_din, output, 16, read data to the CPU.
REQ-012 SHALL have port uart_rx, input, 1, asynchronous serial input, idle high.
REQ-013 SHALL have port uart_tx, output, 1, serial output, idle high.
REQ-014 SHALL have port interrupt_request, output, 1, level request to the CPU.

Function
REQ-015 io_din SHALL be combinational: {8'h00, FIFO head} when io_addr==ADDR_DATA; {10'b0, status[5:0]} when io_addr==ADDR_STAT; 16'h0000 otherwise.
REQ-016 Status bits SHALL be: [0] tx_busy, [1] rx_avail (FIFO not empty), [2] rx_full, [3] overrun (sticky), [4] frame_err (sticky), [5] irq_en.
REQ-017 Reads SHALL be side-effect free except when io_rd is high with io_addr==ADDR_DATA and FIFO not empty; then the FIFO SHALL pop at that clock edge. A pop when empty SHALL be ignored.
REQ-018 io_wr with io_addr==ADDR_DATA while tx idle SHALL load io_dout[7:0]; tx_busy SHALL be high from the next cycle. A write while tx_busy SHALL be dropped without effect.
REQ-019 TX SHALL send 8N1, LSB first: start 0, 8 data bits, stop 1, each exactly CLKS_PER_BIT cycles; tx_busy SHALL clear on the cycle after the stop bit ends (frame = 10*CLKS_PER_BIT cycles).
REQ-020 TX FSM states SHALL be IDLE -> START -> DATA (bit counter 0..7) -> STOP -> IDLE; uart_tx SHALL be registered.
REQ-021 io_wr with io_addr==ADDR_STAT SHALL set irq_en = io_dout[5]; writing 1 to io_dout[3] or io_dout[4] SHALL clear overrun or frame_err respectively; writing 0 SHALL leave them unchanged.
REQ-022 uart_rx SHALL pass a 2-flop synchronizer before any use.
REQ-023 RX FSM states SHALL be IDLE -> START -> DATA -> STOP -> IDLE. IDLE->START on a synchronized falling edge. The start bit SHALL be resampled at CLKS_PER_BIT/2 (integer division); if high, RX SHALL return to IDLE with no flag set (glitch).
REQ-024 Data bits SHALL be sampled every CLKS_PER_BIT cycles after the start midpoint. At the stop midpoint: if stop==1, push the byte; if stop==0, set frame_err, discard the byte, and go to IDLE only after the line is seen high.
REQ-025 A push into a full FIFO SHALL set overrun and discard the new byte; FIFO contents SHALL be unchanged.
REQ-026 A simultaneous push and pop while full SHALL accept both, with no overrun. A simultaneous push and pop while empty SHALL leave the FIFO holding the pushed byte.
REQ-027 FIFO pointers SHALL wrap modulo RXDEPTH; an occupancy counter of log2(RXDEPTH)+1 bits SHALL distinguish full from empty.
REQ-028 interrupt_request SHALL be registered and equal irq_en & rx_avail, delayed by one cycle.
REQ-029 TX and RX SHALL operate fully independently; simultaneous io_wr and a push SHALL both take effect.

Reset
REQ-030 While resetq is low, the block SHALL hold: uart_tx=1, interrupt_request=0, FIFO empty, all status bits 0, both FSMs in IDLE, all counters 0, and synchronizer flops 1.
REQ-031 Reset asserted mid-frame SHALL abort both frames immediately; after release, RX SHALL require a new falling edge before starting.

Verification (CLKS_PER_BIT=8, RXDEPTH=4)
REQ-032 Write 16'h0055 to ADDR_DATA -> uart_tx shows 0,1,0,1,0,1,0,1,0,1, 8 cycles each; status[0]=1 for 80 cycles, then 0.
REQ-033 Serial-drive byte 8'hA3 with a valid stop bit, then write ADDR_STAT=16'h0020 -> status reads 16'h0022 and interrupt_request=1 one cycle later; reading ADDR_DATA with io_rd returns 16'h00A3, after which status reads 16'h0020 and interrupt_request=0.
REQ-034 Drive 5 bytes 01..05 with no reads -> status reads 16'h000E; pops return 01,02,03,04; a write of 16'h0008 to ADDR_STAT clears overrun.
REQ-035 Drive a frame with stop bit 0 -> frame_err=1, FIFO stays empty; drive a 3-cycle low glitch -> no flag set, no byte pushed.
REQ-036 Fill the FIFO, then pop on the exact cycle of the 5th push -> no overrun; subsequent pops return bytes 2..5.
REQ-037 Assert resetq low during TX bit 3 -> uart_tx=1 immediately, status reads 16'h0000, and the next write transmits normally.

Source files
------------

// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART with an RX byte FIFO and a level interrupt.
//   clk, resetq          rising-edge clock, asynchronous active-low reset
//   io_rd, io_wr         one-cycle CPU IO strobes
//   io_addr, io_dout     CPU IO address and write data
//   io_din               combinational read data (data register or status)
//   uart_rx, uart_tx     serial input (asynchronous) and registered serial output
//   interrupt_request    registered irq_en & rx_avail
// Status register: [0] tx_busy [1] rx_avail [2] rx_full [3] overrun [4] frame_err [5] irq_en
module io_uart #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [15:0] ADDR_DATA    = 16'h1000,
    parameter logic [15:0] ADDR_STAT    = 16'h2000,
    parameter int unsigned RXDEPTH      = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        interrupt_request
);
    localparam int unsigned    AW       = $clog2(RXDEPTH);
    localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(RXDEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic wr_data, wr_stat, rd_data;
    assign wr_data = io_wr && (io_addr == ADDR_DATA);
    assign wr_stat = io_wr && (io_addr == ADDR_STAT);
    assign rd_data = io_rd && (io_addr == ADDR_DATA);

    // ---------------- TX ----------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_out_n;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_out_n   = uart_tx;
        case (tx_state)
            TX_IDLE: if (wr_data) begin
                tx_state_n = TX_START;
                tx_cnt_n   = '0;
                tx_shift_n = io_dout[7:0];
                tx_out_n   = 1'b0;
            end
            TX_START: if (tx_cnt == BIT_END) begin
                tx_state_n = TX_DATA;
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                tx_out_n   = tx_shift[0];
            end else tx_cnt_n = tx_cnt + 1'b1;
            TX_DATA: if (tx_cnt == BIT_END) begin
                tx_cnt_n = '0;
                if (tx_bit == 3'd7) begin
                    tx_state_n = TX_STOP;
                    tx_out_n   = 1'b1;
                end else begin
                    tx_bit_n   = tx_bit + 1'b1;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_out_n   = tx_shift[1];
                end
            end else tx_cnt_n = tx_cnt + 1'b1;
            TX_STOP: if (tx_cnt == BIT_END) begin
                tx_state_n = TX_IDLE;
                tx_cnt_n   = '0;
            end else tx_cnt_n = tx_cnt + 1'b1;
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_out_n;
        end
    end

    // ---------------- RX ----------------
    logic          rx_s1, rx_s2, rx_d;
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_brk, rx_brk_n;
    logic          rx_push, rx_ferr_set;

    // A bad stop bit parks the receiver in STOP (rx_brk) until the line returns high,
    // so a held-low line cannot be mistaken for a new start bit.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_brk_n    = rx_brk;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_d && !rx_s2) begin
                rx_state_n = RX_START;
                rx_cnt_n   = '0;
            end
            RX_START: if (rx_cnt == HALF_END) begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            end else rx_cnt_n = rx_cnt + 1'b1;
            RX_DATA: if (rx_cnt == BIT_END) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                else                rx_bit_n   = rx_bit + 1'b1;
            end else rx_cnt_n = rx_cnt + 1'b1;
            RX_STOP: if (rx_brk) begin
                if (rx_s2) begin
                    rx_brk_n   = 1'b0;
                    rx_state_n = RX_IDLE;
                end
            end else if (rx_cnt == BIT_END) begin
                rx_cnt_n = '0;
                if (rx_s2) begin
                    rx_push    = 1'b1;
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_ferr_set = 1'b1;
                    rx_brk_n    = 1'b1;
                end
            end else rx_cnt_n = rx_cnt + 1'b1;
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_brk   <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_brk   <= rx_brk_n;
        end
    end

    // ---------------- FIFO and status ----------------
    logic [7:0]    rx_mem [RXDEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   rx_count;
    logic          rx_avail, rx_full, do_pop, do_push, ovr_set;
    logic          overrun, frame_err, irq_en;
    logic [5:0]    status;

    assign rx_avail = (rx_count != '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign do_pop   = rd_data && rx_avail;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_push  = rx_push && (!rx_full || do_pop);
    assign ovr_set  = rx_push && rx_full && !do_pop;
    assign status   = {irq_en, frame_err, overrun, rx_full, rx_avail, tx_state != TX_IDLE};

    always_ff @(posedge clk) begin
        if (do_push) rx_mem[wptr] <= rx_shift;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr              <= '0;
            rptr              <= '0;
            rx_count          <= '0;
            overrun           <= 1'b0;
            frame_err         <= 1'b0;
            irq_en            <= 1'b0;
            interrupt_request <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      rx_count <= rx_count + 1'b1;
            else if (!do_push && do_pop) rx_count <= rx_count - 1'b1;
            if (wr_stat) begin
                irq_en <= io_dout[5];
                if (io_dout[3]) overrun   <= 1'b0;
                if (io_dout[4]) frame_err <= 1'b0;
            end
            if (ovr_set)     overrun   <= 1'b1;
            if (rx_ferr_set) frame_err <= 1'b1;
            interrupt_request <= irq_en && rx_avail;
        end
    end

    always_comb begin
        io_din = '0;
        if (io_addr == ADDR_DATA)      io_din = {8'h00, rx_mem[rptr]};
        else if (io_addr == ADDR_STAT) io_din = {10'b0, status};
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, io_dout[15:8]};
endmodule
